// File: rtl/test_sequencer.sv
// -----------------------------------------------------------------------------
// test_sequencer
//
// End-of-test controller for a TestHarness run. After reset it holds the
// harness in reset for a fixed number of cycles, then releases it and
// collects success/failure reports from N_AGENTS agents while counting
// elapsed cycles against a budget. When every agent has reported success
// it waits out a drain window, then latches a single pass/fail verdict
// with a reason code. The verdict is held until the next reset.
//
// Optional feature (macro TEST_SEQ_HEARTBEAT_EN): a heartbeat watchdog that
// fails the run when no heartbeat pulse is seen for HB_TIMEOUT RUN cycles.
// Without the macro the heartbeat port is present but ignored.
//
// Parameters
//   N_AGENTS      number of reporting agents (1..32)
//   RESET_CYCLES  cycles harness_reset is held after reset (0 behaves as 1)
//   DRAIN_CYCLES  cycles spent draining after completion (0 = no drain)
//   HB_TIMEOUT    heartbeat watchdog limit in cycles (optional feature)
//
// Ports
//   clock          system clock
//   reset          asynchronous, active-high reset
//   max_cycles     cycle budget, 0 disables the timeout
//   agent_success  per-agent success (level or pulse), accumulated sticky
//   agent_failure  per-agent failure (level or pulse)
//   heartbeat      progress pulse for the optional watchdog
//   harness_reset  reset driven to the harness
//   running        high in RUN or DRAIN
//   done           verdict valid
//   pass / fail    verdict, exactly one set while done=1
//   reason         0 none, 1 pass, 2 agent failure, 3 timeout, 4 heartbeat
//   fail_agent     lowest failing agent index, 0 otherwise
//   cycle_count    cycles elapsed since leaving HOLD (saturating)
// -----------------------------------------------------------------------------
module test_sequencer #(
    parameter int N_AGENTS     = 4,
    parameter int RESET_CYCLES = 16,
    parameter int DRAIN_CYCLES = 8,
    parameter int HB_TIMEOUT   = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [63:0]         max_cycles,
    input  logic [N_AGENTS-1:0] agent_success,
    input  logic [N_AGENTS-1:0] agent_failure,
    input  logic                heartbeat,
    output logic                harness_reset,
    output logic                running,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [2:0]          reason,
    output logic [4:0]          fail_agent,
    output logic [63:0]         cycle_count
);

    localparam logic [2:0] REASON_NONE    = 3'd0;
    localparam logic [2:0] REASON_PASS    = 3'd1;
    localparam logic [2:0] REASON_AGENT   = 3'd2;
    localparam logic [2:0] REASON_TIMEOUT = 3'd3;
    localparam logic [2:0] REASON_HB      = 3'd4;

    // A zero hold length would never release the harness, so clamp to 1.
    localparam int          HOLD_LEN   = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
    localparam logic [31:0] HOLD_T     = HOLD_LEN;
    localparam int          DRAIN_LEN  = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [31:0] DRAIN_LAST = DRAIN_LEN;
    localparam logic [31:0] HB_LIM     = HB_TIMEOUT;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [31:0]         hold_cnt;
    logic [31:0]         drain_cnt;
    logic [N_AGENTS-1:0] mask;

    // Saturating increment: the count sticks at all ones instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [4:0] lowest_set(input logic [N_AGENTS-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = N_AGENTS - 1; i >= 0; i--) begin
            if (v[i]) idx = i[4:0];
        end
        return idx;
    endfunction

    logic [N_AGENTS-1:0] seen_now;
    logic                all_done;
    logic                any_fail;
    logic                timeout_hit;
    logic [63:0]         cc_next;

    // Completion looks at this cycle's success bits too, so a final pulse
    // completes the run on the same edge it arrives.
    assign seen_now    = mask | agent_success;
    assign all_done    = &seen_now;
    assign any_fail    = |agent_failure;
    assign timeout_hit = (max_cycles != 64'd0) && (cycle_count >= max_cycles);
    assign cc_next     = sat_inc(cycle_count);

`ifdef TEST_SEQ_HEARTBEAT_EN
    logic [31:0] wd_cnt;
    logic        hb_expired;

    // A heartbeat in the same cycle rescues the run.
    assign hb_expired = !heartbeat && ((wd_cnt + 32'd1) >= HB_LIM);
`else
    // Heartbeat has no function in this build.
    logic unused_heartbeat;
    assign unused_heartbeat = heartbeat ^ (^HB_LIM);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_HOLD;
            harness_reset <= 1'b1;
            running       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            reason        <= REASON_NONE;
            fail_agent    <= '0;
            cycle_count   <= '0;
            mask          <= '0;
            hold_cnt      <= '0;
            drain_cnt     <= '0;
`ifdef TEST_SEQ_HEARTBEAT_EN
            wd_cnt        <= '0;
`endif
        end else begin
            case (state)
                // ---- HOLD: keep the harness in reset for HOLD_LEN edges ----
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 32'd1;
                    if ((hold_cnt + 32'd1) == HOLD_T) begin
                        state         <= ST_RUN;
                        harness_reset <= 1'b0;
                        running       <= 1'b1;
                        // First RUN cycle reads 1.
                        cycle_count   <= 64'd1;
`ifdef TEST_SEQ_HEARTBEAT_EN
                        wd_cnt        <= '0;
`endif
                    end
                end

                // ---- RUN: failure > completion > heartbeat > timeout ----
                ST_RUN: begin
                    mask <= seen_now;
                    if (any_fail) begin
                        state      <= ST_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        fail       <= 1'b1;
                        reason     <= REASON_AGENT;
                        fail_agent <= lowest_set(agent_failure);
                    end else if (all_done) begin
                        if (DRAIN_CYCLES == 0) begin
                            state   <= ST_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                            reason  <= REASON_PASS;
                        end else begin
                            state       <= ST_DRAIN;
                            drain_cnt   <= '0;
                            cycle_count <= cc_next;
                        end
                    end
`ifdef TEST_SEQ_HEARTBEAT_EN
                    else if (hb_expired) begin
                        state   <= ST_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        reason  <= REASON_HB;
                    end
`endif
                    else if (timeout_hit) begin
                        state   <= ST_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        reason  <= REASON_TIMEOUT;
                    end else begin
                        // cycle_count is frozen on the edge entering DONE,
                        // so it only advances when the run continues.
                        cycle_count <= cc_next;
`ifdef TEST_SEQ_HEARTBEAT_EN
                        wd_cnt      <= heartbeat ? 32'd0 : wd_cnt + 32'd1;
`endif
                    end
                end

                // ---- DRAIN: fixed window, only agent failures can veto ----
                ST_DRAIN: begin
                    if (any_fail) begin
                        state      <= ST_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        fail       <= 1'b1;
                        reason     <= REASON_AGENT;
                        fail_agent <= lowest_set(agent_failure);
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state   <= ST_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                        reason  <= REASON_PASS;
                    end else begin
                        drain_cnt   <= drain_cnt + 32'd1;
                        cycle_count <= cc_next;
                    end
                end

                // ---- DONE: terminal until reset ----
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;

    localparam int NA = 4;

    logic          clock;
    logic          reset;
    logic [63:0]   max_cycles;
    logic [NA-1:0] agent_success;
    logic [NA-1:0] agent_failure;
    logic          heartbeat;
    logic          harness_reset;
    logic          running;
    logic          done;
    logic          pass;
    logic          fail;
    logic [2:0]    reason;
    logic [4:0]    fail_agent;
    logic [63:0]   cycle_count;

    test_sequencer #(
        .N_AGENTS    (NA),
        .RESET_CYCLES(16),
        .DRAIN_CYCLES(8),
        .HB_TIMEOUT  (64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .max_cycles   (max_cycles),
        .agent_success(agent_success),
        .agent_failure(agent_failure),
        .heartbeat    (heartbeat),
        .harness_reset(harness_reset),
        .running      (running),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .reason       (reason),
        .fail_agent   (fail_agent),
        .cycle_count  (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One run: stimulus (success cycles per agent, 0 = never) and verdict.
    typedef struct {
        string           name;
        logic [63:0]     maxc;
        logic [3:0][15:0] s;
        bit              level;
        int              fc;
        logic [3:0]      fmask;
        bit              hb;
        bit              e_pass;
        logic [2:0]      e_reason;
        logic [4:0]      e_fa;
        logic [63:0]     e_cc;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [63:0] maxc,
                                input int s0, input int s1, input int s2, input int s3,
                                input bit level, input int fc, input logic [3:0] fmask,
                                input bit hb, input bit e_pass, input logic [2:0] e_reason,
                                input logic [4:0] e_fa, input logic [63:0] e_cc);
        vec_t v;
        v.name = nm; v.maxc = maxc;
        v.s[0] = s0[15:0]; v.s[1] = s1[15:0]; v.s[2] = s2[15:0]; v.s[3] = s3[15:0];
        v.level = level; v.fc = fc; v.fmask = fmask; v.hb = hb;
        v.e_pass = e_pass; v.e_reason = e_reason; v.e_fa = e_fa; v.e_cc = e_cc;
        return v;
    endfunction

    task automatic idle_inputs();
        agent_success = '0;
        agent_failure = '0;
        heartbeat     = 1'b0;
    endtask

    // Reset, check the reset state, release and check the 16-edge hold.
    // Returns at the negedge inside RUN cycle 1.
    task automatic reset_and_release(input logic [63:0] maxc);
        reset = 1'b1;
        idle_inputs();
        max_cycles = maxc;
        @(negedge clock);
        @(negedge clock);
        chk("rst_harness_reset", harness_reset, 1);
        chk("rst_outputs", {running, done, pass, fail, reason, fail_agent}, 0);
        chk("rst_cycle_count", cycle_count, 0);
        reset = 1'b0;
        repeat (15) @(posedge clock);
        @(negedge clock);
        chk("hold_after_15", harness_reset, 1);
        @(negedge clock);
        chk("release_after_16", harness_reset, 0);
        chk("run_first_cycle", {running, cycle_count}, {1'b1, 64'd1});
    endtask

    // Inputs for RUN/DRAIN cycle k (k equals cycle_count in that cycle).
    task automatic drive(input vec_t v, input int k);
        for (int i = 0; i < NA; i++) begin
            agent_success[i] = (v.s[i] != 0) &&
                               ((int'(v.s[i]) == k) || (v.level && k >= int'(v.s[i])));
        end
        agent_failure = (k == v.fc) ? v.fmask : 4'd0;
        heartbeat     = v.hb && (k <= 200) && ((k % 32) == 8);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        bit   seen;
        logic [63:0] cc_frz;
        reset_and_release(v.maxc);
        exp_q.push_back(v);
        seen = 1'b0;
        for (int k = 1; k <= 700 && !seen; k++) begin
            if (done) seen = 1'b1;
            else begin
                drive(v, k);
                @(negedge clock);
            end
        end
        idle_inputs();
        e = exp_q.pop_front();
        chk({e.name, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({e.name, "_pass"}, pass, e.e_pass);
            chk({e.name, "_fail"}, fail, !e.e_pass);
            chk({e.name, "_reason"}, reason, e.e_reason);
            chk({e.name, "_fail_agent"}, fail_agent, e.e_fa);
            chk({e.name, "_cycle_count"}, cycle_count, e.e_cc);
            chk({e.name, "_idle_outs"}, {running, harness_reset}, 0);
            cc_frz = e.e_cc;
            // DONE must ignore any input activity.
            repeat (5) begin
                agent_success = 4'($urandom_range(0, 15));
                agent_failure = 4'($urandom_range(0, 15));
                heartbeat     = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            idle_inputs();
            chk({e.name, "_frozen"}, {done, pass, reason, fail_agent, cycle_count},
                {1'b1, e.e_pass, e.e_reason, e.e_fa, cc_frz});
        end
    endtask

    initial begin
        reset = 1'b1;
        max_cycles = '0;
        idle_inputs();

        //              name    max  s0 s1 s2 s3 lvl fc fmask hb pass reason fa cc
        vecs[0] = mk("all50",   0,  50, 50, 50, 50, 0,  0, 4'h0, 0, 1, 3'd1, 0, 58);
        vecs[1] = mk("stagger", 0,  10, 20, 30, 40, 0,  0, 4'h0, 0, 1, 3'd1, 0, 48);
        vecs[2] = mk("tmo100",  100,10, 20, 30,  0, 0,  0, 4'h0, 0, 0, 3'd3, 0, 100);
        vecs[3] = mk("failwin", 0,   5, 10, 30, 15, 0, 30, 4'h4, 0, 0, 3'd2, 2, 30);
        vecs[4] = mk("drainf",  0,  20, 20, 20, 20, 0, 24, 4'h2, 0, 0, 3'd2, 1, 24);
        vecs[5] = mk("lowfail", 0,   0,  0,  0,  0, 0,  7, 4'hA, 0, 0, 3'd2, 1, 7);
        vecs[6] = mk("level",   0,   3,  9,  6, 12, 1,  0, 4'h0, 0, 1, 3'd1, 0, 20);
        vecs[7] = mk("tmo1",    1,   0,  0,  0,  0, 0,  0, 4'h0, 0, 0, 3'd3, 0, 1);
        vecs[8] = mk("cmpl_tmo",40, 40, 40, 40, 40, 0,  0, 4'h0, 0, 1, 3'd1, 0, 48);
`ifdef TEST_SEQ_HEARTBEAT_EN
        vecs[9] = mk("hb",      300, 0,  0,  0,  0, 0,  0, 4'h0, 1, 0, 3'd4, 0, 264);
`else
        vecs[9] = mk("hb",      300, 0,  0,  0,  0, 0,  0, 4'h0, 1, 0, 3'd3, 0, 300);
`endif

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Budget disabled: the run must keep going with one agent missing.
        reset_and_release(64'd0);
        for (int k = 1; k <= 800; k++) begin
            agent_success = (k == 3) ? 4'b0111 : 4'b0000;
            @(negedge clock);
        end
        idle_inputs();
        chk("no_budget_running", {done, running}, {1'b0, 1'b1});
        chk("no_budget_count", cycle_count, 801);

        // Asynchronous reset in the middle of DRAIN.
        reset_and_release(64'd0);
        for (int k = 1; k <= 5; k++) begin
            agent_success = (k == 5) ? 4'b1111 : 4'b0000;
            @(negedge clock);
        end
        idle_inputs();
        @(negedge clock);
        chk("drain_before_reset", {running, done, cycle_count}, {1'b1, 1'b0, 64'd7});
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_harness_reset", harness_reset, 1);
        chk("async_outputs", {running, done, pass, fail, reason}, 0);
        chk("async_cycle_count", cycle_count, 0);
        @(negedge clock);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Synthesizable end-of-test controller that sequences a TestHarness run.
- Holds the harness in reset for a fixed number of cycles, then releases it.
- Aggregates per-agent success/failure reports from N harness agents and enforces a cycle budget.
- After a drain window, raises one final pass/fail verdict with a reason code that the enclosing driver uses to end simulation.

Parameters:
- N_AGENTS, 4, number of reporting agents (1..32).
- RESET_CYCLES, 16, cycles harness_reset is held after reset deasserts; a value of 0 is treated as 1.
- DRAIN_CYCLES, 8, cycles spent in DRAIN after all agents succeed; 0 means go straight to DONE.
- HB_TIMEOUT, 1024, heartbeat watchdog limit in cycles (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- max_cycles  in  64  cycle budget; 0 disables the timeout; sampled every cycle
- agent_success  in  N_AGENTS  per-agent success, level or pulse
- agent_failure  in  N_AGENTS  per-agent failure, level or pulse
- heartbeat  in  1  progress pulse; ignored unless TEST_SEQ_HEARTBEAT_EN is defined
- harness_reset  out  1  reset driven to the harness
- running  out  1  high in RUN or DRAIN
- done  out  1  verdict valid
- pass  out  1  verdict is pass (valid only when done=1)
- fail  out  1  verdict is fail (valid only when done=1)
- reason  out  3  0 none, 1 pass, 2 agent failure, 3 timeout, 4 heartbeat
- fail_agent  out  5  index of the lowest failing agent; 0 otherwise
- cycle_count  out  64  cycles elapsed since leaving HOLD

Behaviour:
- Reset is asynchronous and active-high. While reset is high: state=HOLD, harness_reset=1 immediately (not waiting for a clock edge), and running, done, pass, fail, reason, fail_agent, cycle_count, success mask and all internal counters are 0.
- Mid-run reset: asserting reset in any state aborts that state and returns to HOLD with the values above.
- HOLD state:
  - hold counter increments on each rising edge after reset deasserts.
  - On the edge where it reaches max(RESET_CYCLES,1): go to RUN, harness_reset becomes 0.
- RUN state:
  - cycle_count increments every cycle; it reads 1 in the first RUN cycle and saturates at 2^64-1.
  - Sticky mask: mask <= mask | agent_success.
  - Completion occurs when (mask | agent_success) is all ones.
  - Per-cycle priority, highest first:
    - (a) any agent_failure bit set: go to DONE, fail=1, reason=2, fail_agent = lowest set index.
    - (b) completion: go to DRAIN, or to DONE with pass if DRAIN_CYCLES=0.
    - (c) timeout, when max_cycles!=0 and cycle_count >= max_cycles at that edge: go to DONE, fail=1, reason=3.
  - A failure and a completion in the same cycle yields fail, because (a) wins.
- DRAIN state:
  - Lasts exactly DRAIN_CYCLES cycles; cycle_count keeps counting; timeout is not checked.
  - Any agent_failure during DRAIN: go to DONE with fail, reason=2 (overrides the pending pass).
  - Otherwise at drain end: go to DONE, pass=1, reason=1.
- DONE state:
  - Terminal; done=1 and exactly one of pass/fail is set.
  - reason, fail_agent and cycle_count are frozen.
  - running=0 and harness_reset stays 0.
  - All inputs are ignored until reset.
- Output timing: all outputs except harness_reset under async reset are registered; verdict outputs appear on the edge that enters DONE.

Optional Feature:
- Macro: TEST_SEQ_HEARTBEAT_EN.
- When defined:
  - A watchdog counter clears on heartbeat=1 and on entry to RUN, and increments each RUN cycle otherwise.
  - Reaching HB_TIMEOUT forces DONE with fail=1, reason=4.
  - Priority slots between (b) and (c).
  - The watchdog is inactive in DRAIN.
- When undefined: the heartbeat port exists but is unused, no watchdog logic is built, and reason=4 never occurs.

Test Plan:
- RESET_CYCLES=16, N_AGENTS=4, all agent_success pulse at RUN cycle 50, DRAIN_CYCLES=8 -> harness_reset falls after 16 edges; done=1, pass=1, reason=1, cycle_count=58.
- Agents 0..3 pulse success individually at RUN cycles 10, 20, 30, 40 -> DRAIN entered after cycle 40; pass with cycle_count=48.
- max_cycles=100, agent 3 never succeeds -> fail, reason=3, cycle_count=100; with max_cycles=0 the run continues past 10^5 cycles.
- agent_failure[2] and the completing agent_success in the same RUN cycle 30 -> fail, reason=2, fail_agent=2; separately, agent_failure[1] during DRAIN -> fail, reason=2, fail_agent=1.
- Reset asserted mid-DRAIN between clock edges -> harness_reset=1 and done=0 immediately; the full sequence repeats cleanly afterwards.
- With TEST_SEQ_HEARTBEAT_EN and HB_TIMEOUT=64: heartbeat every 32 cycles then stops at cycle 200 -> fail, reason=4 at cycle 264; without the macro the same stimulus never produces reason=4.
